// File: rtl/pattern_load_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pattern_load_sequencer_pkg
//
// Shared types and constants for the pattern data register load sequencer.
//   state_t : sequencer FSM states (IDLE, REQ, LOAD, HOLD)
//   src_t   : load source select, in priority order (CMD > FETCH > CPU)
//   PAT_W   : pattern byte width
//   I_*     : array slot of each source inside the sequencer
// ---------------------------------------------------------------------------
package pattern_load_sequencer_pkg;

    localparam int PAT_W   = 8;
    localparam int NUM_SRC = 3;

    // Slot numbers match the src_t encodings so a slot index and a select
    // value can be compared directly.
    localparam int I_CMD   = 0;
    localparam int I_FETCH = 1;
    localparam int I_CPU   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOAD = 2'd2,
        HOLD = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SRC_CMD   = 2'd0,
        SRC_FETCH = 2'd1,
        SRC_CPU   = 2'd2
    } src_t;

endpackage

// File: rtl/pattern_src_pending.sv
// ---------------------------------------------------------------------------
// pattern_src_pending
//
// One-deep pending request slot for a single pattern load source: a pending
// flag, a data holding register and overrun detection.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   req       in   one-cycle request pulse from the source
//   req_data  in   byte captured together with an accepted request
//   cap       in   late data capture (memory fetch returns data later)
//   cap_data  in   byte stored when cap is high
//   clr       in   sequencer has finished serving this slot (HOLD cycle)
//   pending   out  request outstanding
//   data      out  held byte
//   overrun   out  combinational pulse: request arrived while still pending
// ---------------------------------------------------------------------------
module pattern_src_pending
    import pattern_load_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [PAT_W-1:0] req_data,
    input  logic             cap,
    input  logic [PAT_W-1:0] cap_data,
    input  logic             clr,
    output logic             pending,
    output logic [PAT_W-1:0] data,
    output logic             overrun
);

    logic             pending_reg;
    logic [PAT_W-1:0] data_reg;
    logic             accept;

    // A request in the same cycle the slot is being cleared is a fresh
    // request, not an overrun.
    assign accept  = req && (!pending_reg || clr);
    assign overrun = req && pending_reg && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= 1'b0;
            data_reg    <= '0;
        end else begin
            if (accept) begin
                pending_reg <= 1'b1;
            end else if (clr) begin
                pending_reg <= 1'b0;
            end

            // On overrun the original byte is kept.
            if (accept) begin
                data_reg <= req_data;
            end else if (cap) begin
                data_reg <= cap_data;
            end
        end
    end

    assign pending = pending_reg;
    assign data    = data_reg;

endmodule

// File: rtl/pattern_load_sequencer.sv
// ---------------------------------------------------------------------------
// pattern_load_sequencer
//
// Arbitrates three load sources for the blitter pattern data register
// (command load, memory fetch, CPU write), runs the memory fetch handshake
// and drives the ID bus and the active-low LDPATL latch strobe.
//
// Configuration macro: PATLOAD_CPU_BUFFER_EN
//   defined   : CPU writes get their own pending flag and holding register.
//   undefined : CPU writes are accepted only in IDLE with nothing else
//               pending or arriving; otherwise dropped with PATOVR set.
//
// Ports:
//   MasterClock in   system clock, rising edge
//   RESET       in   asynchronous active-high reset
//   CMDLD/CMDD  in   command load pulse and byte
//   PATFETCH    in   memory fetch request pulse
//   MACK/MD     in   memory acknowledge and read data (same cycle)
//   CPUWR/CPUD  in   CPU write pulse and byte
//   MREQ        out  memory request, high in REQ
//   ID          out  byte presented to the pattern register
//   LDPATL      out  active-low latch enable, low for the LOAD cycle
//   PATBUSY     out  state is not IDLE
//   PATRDY      out  pulse in HOLD after a fetched byte was latched
//   PATOVR      out  sticky overrun flag
// ---------------------------------------------------------------------------
module pattern_load_sequencer
    import pattern_load_sequencer_pkg::*;
(
    input  logic             MasterClock,
    input  logic             RESET,
    input  logic             CMDLD,
    input  logic [PAT_W-1:0] CMDD,
    input  logic             PATFETCH,
    input  logic             MACK,
    input  logic [PAT_W-1:0] MD,
    input  logic             CPUWR,
    input  logic [PAT_W-1:0] CPUD,
    output logic             MREQ,
    output logic [PAT_W-1:0] ID,
    output logic             LDPATL,
    output logic             PATBUSY,
    output logic             PATRDY,
    output logic             PATOVR
);

`ifdef PATLOAD_CPU_BUFFER_EN
    localparam int NUM_BUF = NUM_SRC;
`else
    localparam int NUM_BUF = NUM_SRC - 1;
`endif

    state_t           state_reg, state_next;
    src_t             sel_reg, sel_next;
    logic [PAT_W-1:0] id_reg;
    logic             ovr_reg;

    logic             req_v      [NUM_BUF];
    logic [PAT_W-1:0] req_data_v [NUM_BUF];
    logic             cap_v      [NUM_BUF];
    logic [PAT_W-1:0] cap_data_v [NUM_BUF];
    logic             clr_v      [NUM_BUF];
    logic             pend_v     [NUM_BUF];
    logic [PAT_W-1:0] data_v     [NUM_BUF];
    logic             ovr_v      [NUM_BUF];

    logic             ovr_any;
    logic             cpu_go;
    logic             cpu_drop;
    logic [PAT_W-1:0] data_cpu;
    logic [PAT_W-1:0] load_data;

    // ---------------------------------------------------------------
    // Source slot wiring. The fetch slot has no request data; its byte
    // arrives later through the capture path when MACK is seen in REQ.
    // ---------------------------------------------------------------
    always_comb begin
        req_v[I_CMD]        = CMDLD;
        req_data_v[I_CMD]   = CMDD;
        cap_v[I_CMD]        = 1'b0;
        cap_data_v[I_CMD]   = '0;

        req_v[I_FETCH]      = PATFETCH;
        req_data_v[I_FETCH] = '0;
        cap_v[I_FETCH]      = (state_reg == REQ) && MACK;
        cap_data_v[I_FETCH] = MD;
`ifdef PATLOAD_CPU_BUFFER_EN
        req_v[I_CPU]        = CPUWR;
        req_data_v[I_CPU]   = CPUD;
        cap_v[I_CPU]        = 1'b0;
        cap_data_v[I_CPU]   = '0;
`endif
    end

    generate
        for (genvar gi = 0; gi < NUM_BUF; gi++) begin : g_src
            assign clr_v[gi] = (state_reg == HOLD) && (int'(sel_reg) == gi);

            pattern_src_pending u_pending (
                .clk      (MasterClock),
                .rst      (RESET),
                .req      (req_v[gi]),
                .req_data (req_data_v[gi]),
                .cap      (cap_v[gi]),
                .cap_data (cap_data_v[gi]),
                .clr      (clr_v[gi]),
                .pending  (pend_v[gi]),
                .data     (data_v[gi]),
                .overrun  (ovr_v[gi])
            );
        end
    endgenerate

    always_comb begin
        ovr_any = 1'b0;
        for (int i = 0; i < NUM_BUF; i++) begin
            ovr_any = ovr_any | ovr_v[i];
        end
    end

`ifdef PATLOAD_CPU_BUFFER_EN
    assign cpu_go   = pend_v[I_CPU];
    assign cpu_drop = 1'b0;
    assign data_cpu = data_v[I_CPU];
`else
    // Unbuffered CPU path: a write is taken only when the sequencer would
    // pick it right now. A CMD/FETCH pulse in the same cycle outranks it,
    // so that case also counts as a drop.
    logic             cpu_direct;
    logic [PAT_W-1:0] cpu_reg;

    assign cpu_direct = CPUWR && (state_reg == IDLE) &&
                        !pend_v[I_CMD] && !pend_v[I_FETCH] &&
                        !CMDLD && !PATFETCH;
    assign cpu_go     = cpu_direct;
    assign cpu_drop   = CPUWR && !cpu_direct;
    assign data_cpu   = cpu_reg;

    always_ff @(posedge MasterClock or posedge RESET) begin
        if (RESET) begin
            cpu_reg <= '0;
        end else if (cpu_direct) begin
            cpu_reg <= CPUD;
        end
    end
`endif

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        case (state_reg)
            IDLE: begin
                if (pend_v[I_CMD]) begin
                    state_next = LOAD;
                    sel_next   = SRC_CMD;
                end else if (pend_v[I_FETCH]) begin
                    state_next = REQ;
                    sel_next   = SRC_FETCH;
                end else if (cpu_go) begin
                    state_next = LOAD;
                    sel_next   = SRC_CPU;
                end
            end
            REQ: begin
                if (MACK) begin
                    state_next = LOAD;
                end
            end
            LOAD:    state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        case (sel_reg)
            SRC_CMD:   load_data = data_v[I_CMD];
            SRC_FETCH: load_data = data_v[I_FETCH];
            default:   load_data = data_cpu;
        endcase
    end

    always_ff @(posedge MasterClock or posedge RESET) begin
        if (RESET) begin
            state_reg <= IDLE;
            sel_reg   <= SRC_CMD;
            id_reg    <= '0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            // Remember the latched byte so ID keeps showing it once the
            // sequencer leaves HOLD.
            if (state_reg == HOLD) begin
                id_reg <= load_data;
            end
            ovr_reg <= ovr_reg | ovr_any | cpu_drop;
        end
    end

    // Holding registers do not change during LOAD/HOLD (a re-request in
    // HOLD only lands at the end of HOLD), so ID is stable for the latch.
    assign ID      = ((state_reg == LOAD) || (state_reg == HOLD)) ? load_data : id_reg;
    assign MREQ    = (state_reg == REQ);
    assign LDPATL  = (state_reg != LOAD);
    assign PATBUSY = (state_reg != IDLE);
    assign PATRDY  = (state_reg == HOLD) && (sel_reg == SRC_FETCH);
    assign PATOVR  = ovr_reg;

endmodule

// File: tb/tb_pattern_load_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pattern_load_sequencer
//
// Directed testbench for pattern_load_sequencer. Expectations follow the
// build configuration (PATLOAD_CPU_BUFFER_EN defined or not).
// ---------------------------------------------------------------------------
module tb_pattern_load_sequencer;

`ifdef PATLOAD_CPU_BUFFER_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic       MasterClock = 1'b0;
    logic       RESET       = 1'b1;
    logic       CMDLD       = 1'b0;
    logic [7:0] CMDD        = 8'h00;
    logic       PATFETCH    = 1'b0;
    logic       MACK        = 1'b0;
    logic [7:0] MD          = 8'h00;
    logic       CPUWR       = 1'b0;
    logic [7:0] CPUD        = 8'h00;
    logic       MREQ;
    logic [7:0] ID;
    logic       LDPATL;
    logic       PATBUSY;
    logic       PATRDY;
    logic       PATOVR;

    int checks   = 0;
    int failures = 0;
    int mreq_cnt;

    logic [7:0] loads[$];
    logic [7:0] exp_q[$];

    pattern_load_sequencer dut (
        .MasterClock (MasterClock),
        .RESET       (RESET),
        .CMDLD       (CMDLD),
        .CMDD        (CMDD),
        .PATFETCH    (PATFETCH),
        .MACK        (MACK),
        .MD          (MD),
        .CPUWR       (CPUWR),
        .CPUD        (CPUD),
        .MREQ        (MREQ),
        .ID          (ID),
        .LDPATL      (LDPATL),
        .PATBUSY     (PATBUSY),
        .PATRDY      (PATRDY),
        .PATOVR      (PATOVR)
    );

    always #5 MasterClock = ~MasterClock;

    // Every cycle with LDPATL low is one latched byte.
    always @(negedge MasterClock) begin
        if (LDPATL === 1'b0) begin
            loads.push_back(ID);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge MasterClock);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        tick();
        loads.delete();
    endtask

    task automatic check_loads(input string tag);
        check({tag, "_count"}, loads.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < loads.size()) begin
                check($sformatf("%s_byte%0d", tag, i), loads[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        // ---------------- reset values ----------------
        tick();
        tick();
        check("rst_mreq",    MREQ,    1'b0);
        check("rst_id",      ID,      8'h00);
        check("rst_ldpatl",  LDPATL,  1'b1);
        check("rst_busy",    PATBUSY, 1'b0);
        check("rst_rdy",     PATRDY,  1'b0);
        check("rst_ovr",     PATOVR,  1'b0);
        RESET = 1'b0;
        tick();
        loads.delete();

        // ---------------- CMD load latency ----------------
        CMDD = 8'hA5; CMDLD = 1'b1;
        tick(); CMDLD = 1'b0;                       // n+1
        check("cmd_n1_ldpatl", LDPATL,  1'b1);
        check("cmd_n1_busy",   PATBUSY, 1'b0);
        tick();                                     // n+2
        check("cmd_n2_ldpatl", LDPATL,  1'b0);
        check("cmd_n2_id",     ID,      8'hA5);
        check("cmd_n2_busy",   PATBUSY, 1'b1);
        tick();                                     // n+3
        check("cmd_n3_ldpatl", LDPATL,  1'b1);
        check("cmd_n3_id",     ID,      8'hA5);
        check("cmd_n3_busy",   PATBUSY, 1'b1);
        check("cmd_n3_rdy",    PATRDY,  1'b0);
        tick();                                     // n+4
        check("cmd_n4_busy",   PATBUSY, 1'b0);
        check("cmd_n4_id",     ID,      8'hA5);
        exp_q = {}; exp_q.push_back(8'hA5);
        check_loads("cmd_loads");

        // ---------------- FETCH with delayed MACK ----------------
        loads.delete();
        MD = 8'h3C; PATFETCH = 1'b1;
        tick(); PATFETCH = 1'b0;                    // n+1
        check("fet_n1_mreq", MREQ, 1'b0);
        mreq_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();                                 // n+2 .. n+6
            if (MREQ === 1'b1) mreq_cnt++;
            if (i == 4) MACK = 1'b1;
        end
        tick(); MACK = 1'b0;                        // LOAD
        check("fet_mreq_cycles", mreq_cnt, 5);
        check("fet_load_mreq",   MREQ,   1'b0);
        check("fet_load_ldpatl", LDPATL, 1'b0);
        check("fet_load_id",     ID,     8'h3C);
        check("fet_load_rdy",    PATRDY, 1'b0);
        tick();                                     // HOLD
        check("fet_hold_rdy",    PATRDY, 1'b1);
        check("fet_hold_ldpatl", LDPATL, 1'b1);
        check("fet_hold_id",     ID,     8'h3C);
        tick();
        check("fet_idle_rdy",    PATRDY,  1'b0);
        check("fet_idle_busy",   PATBUSY, 1'b0);

        // ---------------- simultaneous sources ----------------
        do_reset();
        MACK = 1'b1; MD = 8'h33; CMDD = 8'h11; CPUD = 8'h22;
        CMDLD = 1'b1; PATFETCH = 1'b1; CPUWR = 1'b1;
        tick();
        CMDLD = 1'b0; PATFETCH = 1'b0; CPUWR = 1'b0;
        repeat (12) tick();
        MACK = 1'b0;
        exp_q = {}; exp_q.push_back(8'h11); exp_q.push_back(8'h33);
        if (BUF) exp_q.push_back(8'h22);
        check_loads("simul_loads");
        check("simul_ovr", PATOVR, BUF ? 1'b0 : 1'b1);

        // ---------------- CPU writes while fetch waits ----------------
        do_reset();
        PATFETCH = 1'b1;
        tick(); PATFETCH = 1'b0;
        tick();
        check("cpuw_req_mreq", MREQ, 1'b1);
        CPUD = 8'h44; CPUWR = 1'b1;
        tick(); CPUWR = 1'b0;
        check("cpuw_first_ovr", PATOVR, BUF ? 1'b0 : 1'b1);
        tick();
        CPUD = 8'h55; CPUWR = 1'b1;
        tick(); CPUWR = 1'b0;
        check("cpuw_second_ovr", PATOVR, 1'b1);
        tick();
        MD = 8'h66; MACK = 1'b1;
        tick(); MACK = 1'b0;
        repeat (8) tick();
        exp_q = {}; exp_q.push_back(8'h66);
        if (BUF) exp_q.push_back(8'h44);
        check_loads("cpuw_loads");

        // ---------------- CPU write from quiet IDLE ----------------
        do_reset();
        CPUD = 8'h77; CPUWR = 1'b1;
        tick(); CPUWR = 1'b0;
        check("cpu_n1_ldpatl", LDPATL, BUF ? 1'b1 : 1'b0);
        tick();
        check("cpu_n2_ldpatl", LDPATL, BUF ? 1'b0 : 1'b1);
        repeat (4) tick();
        exp_q = {}; exp_q.push_back(8'h77);
        check_loads("cpu_loads");
        check("cpu_ovr", PATOVR, 1'b0);

        // ---------------- CMD overrun keeps first byte ----------------
        do_reset();
        CMDD = 8'hA1; CMDLD = 1'b1;
        tick();
        CMDD = 8'hB2;
        tick(); CMDLD = 1'b0;
        check("cmdovr_ovr", PATOVR, 1'b1);
        repeat (5) tick();
        exp_q = {}; exp_q.push_back(8'hA1);
        check_loads("cmdovr_loads");

        // ---------------- re-request during HOLD ----------------
        do_reset();
        CMDD = 8'hC1; CMDLD = 1'b1;
        tick(); CMDLD = 1'b0;                       // n+1
        tick();                                     // n+2 LOAD
        tick();                                     // n+3 HOLD
        check("hold_busy",   PATBUSY, 1'b1);
        check("hold_ldpatl", LDPATL,  1'b1);
        CMDD = 8'hC2; CMDLD = 1'b1;
        tick(); CMDLD = 1'b0;                       // n+4 IDLE
        check("hold_ovr", PATOVR, 1'b0);
        tick();                                     // n+5 LOAD
        check("hold_reload_ldpatl", LDPATL, 1'b0);
        check("hold_reload_id",     ID,     8'hC2);
        repeat (3) tick();
        exp_q = {}; exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
        check_loads("hold_loads");

        // ---------------- RESET during REQ ----------------
        do_reset();
        PATFETCH = 1'b1;
        tick(); PATFETCH = 1'b0;
        tick();
        check("rreq_mreq_before", MREQ, 1'b1);
        #2 RESET = 1'b1;
        #1;
        check("rreq_mreq_async", MREQ,    1'b0);
        check("rreq_busy",       PATBUSY, 1'b0);
        check("rreq_ldpatl",     LDPATL,  1'b1);
        tick();
        tick();
        RESET = 1'b0;
        MD = 8'hEE; MACK = 1'b1;
        repeat (4) tick();
        MACK = 1'b0;
        check("rreq_mreq_after", MREQ, 1'b0);
        exp_q = {};
        check_loads("rreq_noload");
        CMDD = 8'h5A; CMDLD = 1'b1;
        tick(); CMDLD = 1'b0;
        tick();
        check("rreq_cmd_ldpatl", LDPATL, 1'b0);
        check("rreq_cmd_id",     ID,     8'h5A);
        repeat (3) tick();
        exp_q = {}; exp_q.push_back(8'h5A);
        check_loads("rreq_cmd_loads");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_load_sequencer.md
# pattern_load_sequencer

Sequencer for the blitter's 8-bit pattern data register: it arbitrates between three load sources (blitter command-load, blitter memory fetch, CPU I/O write), runs the memory-fetch handshake, and drives the shared ID bus and the active-low LDPATL latch strobe. It sits between the blitter sequencer, the memory arbiter and the pattern data register, and is the only driver of LDPATL.

## Interface
Parameters:
- none

Ports (clock and reset first):
- MasterClock  input  1  system clock; all state changes on its rising edge
- RESET  input  1  asynchronous, active-high reset
- CMDLD  input  1  one-cycle pulse: load CMDD into the pattern register
- CMDD  input  8  command-sourced pattern byte, valid with CMDLD
- PATFETCH  input  1  one-cycle pulse: fetch a pattern byte from memory
- MACK  input  1  memory arbiter acknowledge; MD valid in the same cycle
- MD  input  8  memory read data
- CPUWR  input  1  one-cycle pulse: CPU write to the pattern register
- CPUD  input  8  CPU write data, valid with CPUWR
- MREQ  output  1  memory request; held high until MACK
- ID  output  8  byte presented to the pattern register
- LDPATL  output  1  active-low latch enable for the pattern register
- PATBUSY  output  1  high whenever state is not IDLE
- PATRDY  output  1  one-cycle pulse when a memory-fetched byte has been latched
- PATOVR  output  1  sticky overrun flag; cleared only by RESET

## Operation
- FSM states: IDLE, REQ, LOAD, HOLD.
- Each load source has a one-deep pending flag plus a data holding register: CMD (with CMDD), FETCH (request only), CPU (with CPUD).
- Source selection in IDLE, fixed priority: CMD > FETCH > CPU.
- IDLE -> LOAD for a CMD or CPU source. IDLE -> REQ for FETCH.
- REQ: MREQ=1. When MACK=1, MD is captured into the holding register and the FSM goes to LOAD.
- LOAD: ID = selected byte, LDPATL=0 for exactly one cycle, then HOLD.
- HOLD: ID is unchanged, LDPATL=1, and the selected pending flag clears. If the source was FETCH, PATRDY pulses. HOLD always returns to IDLE.
- A request pulse that arrives while the same source's flag is already set sets PATOVR. The new request is dropped and the original data is kept.
- Simultaneous pulses on different sources are all captured and served in priority order.
- A request pulse in the same cycle its flag clears (HOLD) is accepted as a new pending request.
- In all states except LOAD and HOLD, ID shows the last value driven.

## Timing
- Reset values: MREQ=0, ID=8'h00, LDPATL=1, PATBUSY=0, PATRDY=0, PATOVR=0, state IDLE, all pending flags clear.
- RESET asserted mid-operation: MREQ drops immediately (asynchronous), pending requests are lost, and no LDPATL pulse is issued.
- Latency for CMD or CPU: pulse at cycle n, LDPATL low in cycle n+2 (flag set at n+1 edge, LOAD at n+2), PATBUSY high from n+2 through n+3.
- Latency for FETCH: MREQ high from cycle n+2. If MACK arrives at cycle m, LDPATL is low in m+1 and PATRDY pulses in m+2.
- ID is stable from the LOAD cycle through the end of HOLD, which satisfies the transparent latch's hold requirement.
- Worst case with back-to-back sources is one load per 3 cycles (IDLE, LOAD, HOLD), not counting MACK wait time.

## Configuration
- PATLOAD_CPU_BUFFER_EN defined: CPU writes use the pending flag and holding register as described above.
- Undefined: there is no CPU holding register. A CPUWR in IDLE with no other request pending goes straight to LOAD, using CPUD registered in that cycle. A CPUWR in any other situation is dropped and sets PATOVR.

## Structure
- Shared package holds:
  - the state enum (IDLE, REQ, LOAD, HOLD)
  - the source-select enum (SRC_CMD, SRC_FETCH, SRC_CPU)
  - the pattern width constant PAT_W = 8
- A sub-module, pattern_src_pending, is natural: one pending flag, data register and overrun detection, instantiated once per source.

## Test plan
- Reset, then CMDLD with CMDD=8'hA5 -> LDPATL low for one cycle two cycles later, ID=8'hA5 held for 2 cycles, PATRDY stays 0.
- PATFETCH, MACK delayed 4 cycles with MD=8'h3C -> MREQ high 5 cycles, then LDPATL low with ID=8'h3C, then PATRDY pulse.
- CMDLD (8'h11), PATFETCH and CPUWR (8'h22) in the same cycle, MACK immediate with MD=8'h33 -> loads in the order 8'h11, 8'h33, 8'h22, PATOVR stays 0.
- Two CPUWR pulses while a fetch waits on MACK -> PATOVR=1, and the first CPU byte is the one loaded. Without the macro, the first CPUWR already sets PATOVR and no CPU load occurs.
- RESET asserted during REQ -> MREQ=0 asynchronously, no LDPATL pulse, PATBUSY=0, and a subsequent CMDLD works normally.
